// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder
// Emulates the bus side of a character-LCD controller so that an LCD driver
// can be exercised without a real panel. The asynchronous driver bus
// (rs/rw/en/dat) is synchronized into clk. A transaction is taken on the
// falling edge of the synchronized enable. The block keeps a 64-byte shadow
// of display RAM, an address counter (AC) with an entry direction, and an
// emulated busy flag.
//
// Ports
//   clk        system clock (only clock)
//   rst_n      asynchronous active-low reset
//   rs, rw, en LCD control lines from the driver (asynchronous to clk)
//   dat        LCD data bus, driver side
//   dat_rd     byte returned to the driver during read cycles (0 when idle)
//   dat_oe     high while dat_rd is valid (synchronized rw and en both high)
//   rd_addr    host/checker shadow-RAM read address
//   rd_data    shadow byte at rd_addr, one cycle of latency
//   busy       emulated busy flag (BUSY or CLEARING)
//   cmd_valid  one-cycle pulse per accepted instruction write
//   cmd_code   last accepted instruction byte
//   err_busy   sticky: a write strobe arrived while busy
module lcd_bus_responder #(
  parameter int          BUSY_CYCLES = 3600,
  parameter logic [7:0]  CLEAR_FILL  = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs,
  input  logic       rw,
  input  logic       en,
  input  logic [7:0] dat,
  output logic [7:0] dat_rd,
  output logic       dat_oe,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       err_busy
);

  // The busy counter holds BUSY_CYCLES-1 down to 0.
  localparam int CW = (BUSY_CYCLES > 2) ? $clog2(BUSY_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(BUSY_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY     = 2'd1,
    ST_CLEARING = 2'd2
  } state_t;

  // AC step in the current entry direction; 6-bit arithmetic wraps mod 64.
  function automatic logic [5:0] ac_step(input logic [5:0] a, input logic inc);
    ac_step = inc ? (a + 6'd1) : (a - 6'd1);
  endfunction

  // Synchronizer stages and the previous synchronized enable.
  logic       rs_meta_r, rs_sync_r;
  logic       rw_meta_r, rw_sync_r;
  logic       en_meta_r, en_sync_r, en_prev_r;
  logic [7:0] dat_meta_r, dat_sync_r;

  state_t          state_r, state_nx_s;
  logic [5:0]      ac_r, ac_nx_s;
  logic            dir_r, dir_nx_s;
  logic [CW-1:0]   cnt_r, cnt_nx_s;
  logic [5:0]      fill_r, fill_nx_s;
  logic            cmd_valid_r;
  logic [7:0]      cmd_code_r;
  logic            err_busy_r;
  logic [7:0]      rd_data_r;

  logic            fall_s;
  logic            cmd_acc_s;
  logic            err_set_s;
  logic            wr_en_s;
  logic [5:0]      wr_addr_s;
  logic [7:0]      wr_data_s;

  logic [7:0]      shadow_r [64];

  // Falling edge of the synchronized enable marks the transaction cycle.
  assign fall_s = en_prev_r & ~en_sync_r;

  // Next-state, AC/direction updates and shadow write request.
  always_comb begin
    state_nx_s = state_r;
    ac_nx_s    = ac_r;
    dir_nx_s   = dir_r;
    cnt_nx_s   = cnt_r;
    fill_nx_s  = fill_r;
    cmd_acc_s  = 1'b0;
    err_set_s  = 1'b0;
    wr_en_s    = 1'b0;
    wr_addr_s  = ac_r;
    wr_data_s  = dat_sync_r;
    case (state_r)
      ST_IDLE: begin
        if (fall_s && !rw_sync_r) begin
          if (rs_sync_r) begin
            // Data write.
            wr_en_s    = 1'b1;
            ac_nx_s    = ac_step(ac_r, dir_r);
            state_nx_s = ST_BUSY;
            cnt_nx_s   = CNT_LOAD;
          end else begin
            // Instruction write.
            cmd_acc_s = 1'b1;
            if (dat_sync_r == 8'h01) begin
              ac_nx_s    = 6'd0;
              dir_nx_s   = 1'b1;
              fill_nx_s  = 6'd0;
              state_nx_s = ST_CLEARING;
            end else begin
              if (dat_sync_r[7:1] == 7'b0000001) begin
                ac_nx_s = 6'd0;
              end else if (dat_sync_r[7:2] == 6'b000001) begin
                dir_nx_s = dat_sync_r[1];
              end else if (dat_sync_r[7:6] == 2'b10) begin
                ac_nx_s = dat_sync_r[5:0];
              end else begin
                ac_nx_s = ac_r;
              end
              state_nx_s = ST_BUSY;
              cnt_nx_s   = CNT_LOAD;
            end
          end
        end else if (fall_s && rs_sync_r) begin
          // Data read completes: step AC, no busy period.
          ac_nx_s = ac_step(ac_r, dir_r);
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        err_set_s = fall_s & ~rw_sync_r;
        if (cnt_r == '0) begin
          state_nx_s = ST_IDLE;
        end else begin
          cnt_nx_s = cnt_r - 1'b1;
        end
      end
      ST_CLEARING: begin
        err_set_s = fall_s & ~rw_sync_r;
        wr_en_s   = 1'b1;
        wr_addr_s = fill_r;
        wr_data_s = CLEAR_FILL;
        fill_nx_s = fill_r + 6'd1;
        if (fill_r == 6'd63) begin
          state_nx_s = ST_BUSY;
          cnt_nx_s   = CNT_LOAD;
        end else begin
          state_nx_s = ST_CLEARING;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Synchronizers, controller state and registered host-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_meta_r   <= 1'b0;
      rs_sync_r   <= 1'b0;
      rw_meta_r   <= 1'b0;
      rw_sync_r   <= 1'b0;
      en_meta_r   <= 1'b0;
      en_sync_r   <= 1'b0;
      en_prev_r   <= 1'b0;
      dat_meta_r  <= 8'h00;
      dat_sync_r  <= 8'h00;
      state_r     <= ST_IDLE;
      ac_r        <= 6'd0;
      dir_r       <= 1'b1;
      cnt_r       <= '0;
      fill_r      <= 6'd0;
      cmd_valid_r <= 1'b0;
      cmd_code_r  <= 8'h00;
      err_busy_r  <= 1'b0;
      rd_data_r   <= 8'h00;
    end else begin
      rs_meta_r   <= rs;
      rs_sync_r   <= rs_meta_r;
      rw_meta_r   <= rw;
      rw_sync_r   <= rw_meta_r;
      en_meta_r   <= en;
      en_sync_r   <= en_meta_r;
      en_prev_r   <= en_sync_r;
      dat_meta_r  <= dat;
      dat_sync_r  <= dat_meta_r;
      state_r     <= state_nx_s;
      ac_r        <= ac_nx_s;
      dir_r       <= dir_nx_s;
      cnt_r       <= cnt_nx_s;
      fill_r      <= fill_nx_s;
      cmd_valid_r <= cmd_acc_s;
      if (cmd_acc_s) begin
        cmd_code_r <= dat_sync_r;
      end else begin
        cmd_code_r <= cmd_code_r;
      end
      err_busy_r  <= err_busy_r | err_set_s;
      // Reads the pre-write value when the same location is written now.
      rd_data_r   <= shadow_r[rd_addr];
    end
  end

  // Shadow RAM is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      shadow_r[wr_addr_s] <= wr_data_s;
    end
  end

  assign busy      = (state_r != ST_IDLE);
  assign dat_oe    = rw_sync_r & en_sync_r;
  assign dat_rd    = !dat_oe    ? 8'h00 :
                     rs_sync_r  ? shadow_r[ac_r] :
                                  {busy, 1'b0, ac_r};
  assign rd_data   = rd_data_r;
  assign cmd_valid = cmd_valid_r;
  assign cmd_code  = cmd_code_r;
  assign err_busy  = err_busy_r;

endmodule

// File: doc/lcd_bus_responder.md
LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

Interface
REQ-001 Parameter: BUSY_CYCLES, default 3600, clk cycles busy after a normal command or data write (72 us at 50 MHz).
REQ-002 Parameter: CLEAR_FILL, default 8'h20, byte written to every shadow location by the clear command.
REQ-003 Port: clk  in  1  system clock; the only clock.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: rs  in  1  register select from the LCD driver (0 = instruction, 1 = data).
REQ-006 Port: rw  in  1  read/write from the LCD driver (1 = read).
REQ-007 Port: en  in  1  LCD enable strobe; asynchronous to clk.
REQ-008 Port: dat  in  8  LCD data bus, driver side.
REQ-009 Port: dat_rd  out  8  data returned to the driver during read cycles.
REQ-010 Port: dat_oe  out  1  high while dat_rd is valid (rw=1 and en high).
REQ-011 Port: rd_addr  in  6  shadow-RAM read address for the checker/host.
REQ-012 Port: rd_data  out  8  shadow-RAM byte at rd_addr, one-cycle latency.
REQ-013 Port: busy  out  1  emulated controller busy flag.
REQ-014 Port: cmd_valid  out  1  one-cycle pulse per accepted instruction write.
REQ-015 Port: cmd_code  out  8  last accepted instruction byte.
REQ-016 Port: err_busy  out  1  sticky; a write strobe arrived while busy.

Function
REQ-017 rs, rw, en and dat SHALL each pass through a 2-flop synchronizer before use; all decisions use the synchronized values.
REQ-018 A transaction SHALL be taken on the falling edge of synchronized en, using rs/rw/dat sampled in the same cycle as the en 1->0 detection.
REQ-019 State machine SHALL have states IDLE, BUSY, CLEARING; reset state IDLE.
REQ-020 Write strobes (rw=0) SHALL be accepted only in IDLE; in BUSY or CLEARING they are discarded and err_busy is set to 1.
REQ-021 Data write (rs=1, rw=0): shadow[AC] <= dat; AC steps by the entry direction; state -> BUSY.
REQ-022 AC SHALL be 6 bits and wrap modulo 64 in both directions (63+1 -> 0, 0-1 -> 63).
REQ-023 Instruction write (rs=0, rw=0): cmd_code <= dat; cmd_valid pulses one cycle later; decode as below.
REQ-024 8'h01 clear: AC <= 0, direction <= increment, state -> CLEARING; shadow[0..63] written with CLEAR_FILL one location per cycle; after the 64th write -> BUSY for BUSY_CYCLES.
REQ-025 8'h02/8'h03 home: AC <= 0; state -> BUSY.
REQ-026 8'h04-8'h07 entry mode: direction <= dat[1] (1 = increment); state -> BUSY.
REQ-027 8'h80-8'hBF set address: AC <= dat[5:0]; state -> BUSY.
REQ-028 All other instruction bytes: no internal change beyond cmd_code/cmd_valid; state -> BUSY.
REQ-029 BUSY SHALL last exactly BUSY_CYCLES clk cycles counted from the cycle after the strobe, then -> IDLE; busy = 1 in BUSY and CLEARING.
REQ-030 Status read (rs=0, rw=1): while synchronized en high, dat_rd = {busy, 1'b0, AC}; falling en has no side effect; allowed in any state.
REQ-031 Data read (rs=1, rw=1): while en high, dat_rd = shadow[AC]; on falling en AC steps by the entry direction; accepted only in IDLE, otherwise ignored without error.
REQ-032 dat_oe = synchronized rw AND synchronized en; dat_rd = 8'h00 when dat_oe = 0.
REQ-033 rd_addr port SHALL read independently of bus activity; if the same location is written in the same cycle, rd_data returns the old value.
REQ-034 Shadow RAM: 64 x 8, one write port (bus or clear fill), one read port for rd_addr plus the AC read path.

Reset
REQ-035 rst_n low SHALL asynchronously force: state IDLE, AC 0, direction increment, busy 0, cmd_valid 0, cmd_code 8'h00, err_busy 0, dat_oe 0, dat_rd 8'h00, synchronizers 0.
REQ-036 Shadow RAM contents SHALL NOT be cleared by reset; reset mid-CLEARING leaves remaining locations unchanged.

Verification
REQ-037 Reset, set-address 8'h80, data writes 8'h31,8'h32 each after busy drops -> shadow[0]=8'h31, shadow[1]=8'h32, AC=2, cmd_valid exactly once.
REQ-038 Set-address 8'hBF, data write 8'h41, then 8'h42 -> shadow[63]=8'h41, shadow[0]=8'h42 (wrap).
REQ-039 Entry mode 8'h04, set-address 8'h80, data write 8'h55 -> shadow[0]=8'h55, status read returns 8'hBF while busy then 8'h3F.
REQ-040 Clear 8'h01 -> busy for 64+BUSY_CYCLES cycles, all 64 locations read 8'h20 via rd_addr, AC=0.
REQ-041 Data write issued 10 cycles after a previous write -> discarded, err_busy=1 and held until rst_n low.
REQ-042 rst_n asserted mid-BUSY -> busy=0 immediately, next write accepted, shadow contents prior to reset intact.
